// File: rtl/alu_muldiv_ctrl_if.sv
// Bundle between the main decoder and the ALU control / mul-div unit.
//   master: drives alu_op, funct, instr_valid, src_a, src_b; sees decode results and HI/LO.
//   slave : the alu_muldiv_ctrl block itself.
interface alu_muldiv_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic             instr_valid;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [3:0]       operation;
  logic [1:0]       wb_sel;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;

  modport master (
    output alu_op, funct, instr_valid, src_a, src_b,
    input  operation, wb_sel, hi, lo, busy, stall
  );

  modport slave (
    input  alu_op, funct, instr_valid, src_a, src_b,
    output operation, wb_sel, hi, lo, busy, stall
  );
endinterface

// File: rtl/alu_muldiv_ctrl.sv
// ALU control with a sequential multiply/divide unit and HI/LO registers.
//   clk, rst : clock and synchronous active-high reset.
//   bus      : decoder-facing bundle (alu_op/funct/instr_valid/src_a/src_b in;
//              operation, wb_sel, hi, lo, busy, stall out).
// Multiply is shift-add, divide is restoring; both run on magnitudes for one
// step per cycle over WIDTH cycles, then a single FIX cycle applies signs.
module alu_muldiv_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  alu_muldiv_ctrl_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;   // product upper half / partial remainder
  logic [WIDTH-1:0] lsw_q;   // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] opb_q;   // |multiplicand| or |divisor|
  logic [CntW-1:0]  cnt_q;
  logic             is_div_q, is_signed_q, sign_a_q, sign_b_q, div0_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  // Group decode
  logic md_start, mf_hi, mf_lo, mt_hi, mt_lo, grp;

  always_comb begin
    md_start = 1'b0;
    mf_hi    = 1'b0;
    mf_lo    = 1'b0;
    mt_hi    = 1'b0;
    mt_lo    = 1'b0;
    if (bus.instr_valid && bus.alu_op == 2'b10) begin
      case (bus.funct)
        6'b011000, 6'b011001, 6'b011010, 6'b011011: md_start = 1'b1;
        6'b010000: mf_hi = 1'b1;
        6'b010010: mf_lo = 1'b1;
        6'b010001: mt_hi = 1'b1;
        6'b010011: mt_lo = 1'b1;
        default: ;
      endcase
    end
  end

  assign grp       = md_start | mf_hi | mf_lo | mt_hi | mt_lo;
  assign bus.busy  = (state_q != StIdle);
  assign bus.stall = bus.busy & grp;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

  always_comb begin
    bus.wb_sel = 2'b00;
    if (mf_hi) bus.wb_sel = 2'b01;
    if (mf_lo) bus.wb_sel = 2'b10;
  end

  always_comb begin
    bus.operation = 4'b0010;
    case (bus.alu_op)
      2'b00: bus.operation = 4'b0010;
      2'b01: bus.operation = 4'b0110;
      2'b11: bus.operation = 4'b0111;
      default: begin
        case (bus.funct)
          6'b100000: bus.operation = 4'b0010;
          6'b100010: bus.operation = 4'b0110;
          6'b100100: bus.operation = 4'b0000;
          6'b100101: bus.operation = 4'b0001;
          6'b101010: bus.operation = 4'b0111;
          6'b100111: bus.operation = 4'b1100;
          default:   bus.operation = 4'b0010;
        endcase
      end
    endcase
  end

  // Operand magnitudes; funct[0]=0 selects the signed variants.
  logic             start_signed;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign start_signed = ~bus.funct[0];
  assign abs_a = (start_signed && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
  assign abs_b = (start_signed && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;

  // One iteration of each engine
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;

  assign mul_sum = {1'b0, acc_q} + (lsw_q[0] ? {1'b0, opb_q} : '0);
  assign rem_sh  = {acc_q, lsw_q[WIDTH-1]};
  assign rem_ge  = (rem_sh >= {1'b0, opb_q});
  assign rem_sub = rem_sh[WIDTH-1:0] - opb_q;

  // Sign fix-up
  logic [2*WIDTH-1:0] prod_abs, prod;
  logic [WIDTH-1:0]   quot, rem;
  logic               neg_res;

  assign neg_res  = is_signed_q & (sign_a_q ^ sign_b_q);
  assign prod_abs = {acc_q, lsw_q};
  assign prod     = neg_res ? -prod_abs : prod_abs;
  assign quot     = div0_q ? '1 : (neg_res ? -lsw_q : lsw_q);
  // Remainder follows the dividend; with a zero divisor this rebuilds src_a.
  assign rem      = (is_signed_q && sign_a_q) ? -acc_q : acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      lsw_q       <= '0;
      opb_q       <= '0;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      div0_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (md_start) begin
            acc_q       <= '0;
            lsw_q       <= abs_a;
            opb_q       <= abs_b;
            cnt_q       <= '0;
            is_div_q    <= bus.funct[1];
            is_signed_q <= start_signed;
            sign_a_q    <= bus.src_a[WIDTH-1];
            sign_b_q    <= bus.src_b[WIDTH-1];
            div0_q      <= (bus.src_b == '0);
            state_q     <= StRun;
          end
          if (mt_hi) hi_q <= bus.src_a;
          if (mt_lo) lo_q <= bus.src_a;
        end
        StRun: begin
          if (is_div_q) begin
            acc_q <= rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
            lsw_q <= {lsw_q[WIDTH-2:0], rem_ge};
          end else begin
            acc_q <= mul_sum[WIDTH:1];
            lsw_q <= {mul_sum[0], lsw_q[WIDTH-1:1]};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) state_q <= StFix;
        end
        StFix: begin
          if (is_div_q) begin
            hi_q <= rem;
            lo_q <= quot;
          end else begin
            hi_q <= prod[2*WIDTH-1:WIDTH];
            lo_q <= prod[WIDTH-1:0];
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
module tb_alu_muldiv_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_muldiv_ctrl_if #(.WIDTH(32)) bus ();

  alu_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0] alu_op;
    logic [5:0] funct;
    logic       valid;
    logic [3:0] exp_op;
    logic [1:0] exp_wb;
  } dec_vec_t;

  typedef struct {
    string      name;
    logic [5:0] funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } md_vec_t;

  dec_vec_t dec_tbl[14];
  md_vec_t  md_tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic v,
                       input logic [31:0] a, input logic [31:0] b);
    bus.alu_op      = op;
    bus.funct       = f;
    bus.instr_valid = v;
    bus.src_a       = a;
    bus.src_b       = b;
  endtask

  // Issue an instruction for one cycle; returns at the negedge after the accepting edge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    drive(2'b10, f, 1'b1, a, b);
    @(negedge clk);
    drive(2'b00, 6'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic wait_idle(input string name, output int cycles);
    cycles = 0;
    while (bus.busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    if (bus.busy) check({name, "_timeout"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int cyc;

    dec_tbl[0]  = '{2'b00, 6'b000000, 1'b1, 4'b0010, 2'b00};
    dec_tbl[1]  = '{2'b01, 6'b000000, 1'b1, 4'b0110, 2'b00};
    dec_tbl[2]  = '{2'b11, 6'b000000, 1'b1, 4'b0111, 2'b00};
    dec_tbl[3]  = '{2'b10, 6'b100000, 1'b1, 4'b0010, 2'b00};
    dec_tbl[4]  = '{2'b10, 6'b100010, 1'b1, 4'b0110, 2'b00};
    dec_tbl[5]  = '{2'b10, 6'b100100, 1'b1, 4'b0000, 2'b00};
    dec_tbl[6]  = '{2'b10, 6'b100101, 1'b1, 4'b0001, 2'b00};
    dec_tbl[7]  = '{2'b10, 6'b101010, 1'b1, 4'b0111, 2'b00};
    dec_tbl[8]  = '{2'b10, 6'b100111, 1'b1, 4'b1100, 2'b00};
    dec_tbl[9]  = '{2'b10, 6'b010000, 1'b1, 4'b0010, 2'b01};
    dec_tbl[10] = '{2'b10, 6'b010010, 1'b1, 4'b0010, 2'b10};
    dec_tbl[11] = '{2'b10, 6'b111111, 1'b1, 4'b0010, 2'b00};
    dec_tbl[12] = '{2'b10, 6'b010000, 1'b0, 4'b0010, 2'b00};
    dec_tbl[13] = '{2'b00, 6'b010010, 1'b1, 4'b0010, 2'b00};

    md_tbl[0] = '{"mult_m3x5",  6'b011000, 32'hFFFFFFFD, 32'h5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    md_tbl[1] = '{"multu_m3x5", 6'b011001, 32'hFFFFFFFD, 32'h5,        32'h00000004, 32'hFFFFFFF1};
    md_tbl[2] = '{"div_7_m2",   6'b011010, 32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    md_tbl[3] = '{"divu_big",   6'b011011, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF};
    md_tbl[4] = '{"div_min_m1", 6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    md_tbl[5] = '{"div_5_0",    6'b011010, 32'h5,        32'h0,        32'h00000005, 32'hFFFFFFFF};
    md_tbl[6] = '{"div_m5_0",   6'b011010, 32'hFFFFFFFB, 32'h0,        32'hFFFFFFFB, 32'hFFFFFFFF};

    drive(2'b00, 6'd0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_hi", 64'(bus.hi), 64'd0);
    check("reset_lo", 64'(bus.lo), 64'd0);
    check("reset_stall", 64'(bus.stall), 64'd0);

    // Combinational decode sweep
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(dec_tbl[i].alu_op, dec_tbl[i].funct, dec_tbl[i].valid, 32'd0, 32'd0);
      #1;
      check($sformatf("dec%0d_op", i), 64'(bus.operation), 64'(dec_tbl[i].exp_op));
      check($sformatf("dec%0d_wb", i), 64'(bus.wb_sel), 64'(dec_tbl[i].exp_wb));
      check($sformatf("dec%0d_stall", i), 64'(bus.stall), 64'd0);
    end
    drive(2'b00, 6'd0, 1'b0, 32'd0, 32'd0);

    // Multiply/divide results and latency
    for (int i = 0; i < 7; i++) begin
      issue(md_tbl[i].funct, md_tbl[i].a, md_tbl[i].b);
      wait_idle(md_tbl[i].name, cyc);
      check({md_tbl[i].name, "_busy_cycles"}, 64'(cyc), 64'd33);
      check({md_tbl[i].name, "_hi"}, 64'(bus.hi), 64'(md_tbl[i].exp_hi));
      check({md_tbl[i].name, "_lo"}, 64'(bus.lo), 64'(md_tbl[i].exp_lo));
    end

    // mflo right behind a mult stalls until the product lands
    @(negedge clk);
    drive(2'b10, 6'b011000, 1'b1, 32'd6, 32'd7);
    @(negedge clk);
    drive(2'b10, 6'b010010, 1'b1, 32'd0, 32'd0);
    cyc = 0;
    while (bus.stall && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check("mflo_stall_cycles", 64'(cyc), 64'd33);
    check("mflo_busy_after", 64'(bus.busy), 64'd0);
    check("mflo_lo", 64'(bus.lo), 64'd42);
    check("mflo_wb_sel", 64'(bus.wb_sel), 64'd2);
    drive(2'b00, 6'd0, 1'b0, 32'd0, 32'd0);

    // Plain add while busy does not stall
    issue(6'b011001, 32'd2, 32'd3);
    drive(2'b10, 6'b100000, 1'b1, 32'd0, 32'd0);
    #1;
    check("add_busy", 64'(bus.busy), 64'd1);
    check("add_stall", 64'(bus.stall), 64'd0);
    check("add_op", 64'(bus.operation), 64'd2);
    drive(2'b00, 6'd0, 1'b0, 32'd0, 32'd0);
    wait_idle("add_wait", cyc);
    check("multu_2x3_lo", 64'(bus.lo), 64'd6);

    // mthi / mtlo in idle
    issue(6'b010001, 32'h1234, 32'd0);
    check("mthi_hi", 64'(bus.hi), 64'h1234);
    check("mthi_busy", 64'(bus.busy), 64'd0);
    issue(6'b010011, 32'hABCD, 32'd0);
    check("mtlo_lo", 64'(bus.lo), 64'hABCD);
    check("mtlo_hi_kept", 64'(bus.hi), 64'h1234);

    // Reset partway through a mult
    issue(6'b011000, 32'hFFFFFFFD, 32'd5);
    repeat (9) @(negedge clk);
    check("pre_rst_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    check("rst_mid_hi", 64'(bus.hi), 64'd0);
    check("rst_mid_lo", 64'(bus.lo), 64'd0);
    issue(6'b011001, 32'd3, 32'd4);
    wait_idle("post_rst", cyc);
    check("post_rst_cycles", 64'(cyc), 64'd33);
    check("post_rst_lo", 64'(bus.lo), 64'd12);
    check("post_rst_hi", 64'(bus.hi), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_ctrl.md
Name:
alu_muldiv_ctrl

Overview:
Parametrised successor to the single-cycle ALU control. It decodes ALUOp/funct into the 4-bit ALU operation, as before, and adds the R-type NOR plus slti support. It also owns a sequential multiply/divide unit with HI/LO registers, covering mult/multu/div/divu/mfhi/mflo/mthi/mtlo. It sits between the main decoder and the ALU/writeback mux, and stalls the pipeline while a multi-cycle operation is in flight.

Parameters:
WIDTH, 32, operand/HI/LO width in bits; iteration count of the mul/div engine.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, synchronous, active-high.
alu_op  input  2  ALUOp from main decoder.
funct  input  6  R-type funct field.
instr_valid  input  1  current instruction is real (not bubble).
src_a  input  WIDTH  rs value (multiplicand/dividend, mthi/mtlo data).
src_b  input  WIDTH  rt value (multiplier/divisor).
operation  output  4  ALU operation code (combinational).
wb_sel  output  2  writeback source: 00 ALU, 01 HI, 10 LO (combinational).
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.
busy  output  1  mul/div engine running.
stall  output  1  hold upstream pipeline this cycle (combinational).

Behaviour:
- operation decode (combinational, no state):
  - alu_op 00 -> 0010 (add).
  - alu_op 01 -> 0110 (sub).
  - alu_op 11 -> 0111 (slt, slti).
  - alu_op 10 by funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, 100111 -> 1100 (nor).
  - All other funct values -> 0010.
- Mul/div/HI-LO group, decoded only when alu_op==10 and instr_valid==1:
  - md_start: funct 011000 mult, 011001 multu, 011010 div, 011011 divu.
  - mf: 010000 mfhi (wb_sel=01), 010010 mflo (wb_sel=10).
  - mt: 010001 mthi, 010011 mtlo.
  - Otherwise wb_sel=00.
- stall = busy & instr_valid & alu_op==10 & funct in {md_start, mf, mt}. Non-HI/LO instructions never stall.
- FSM states IDLE, RUN, FIX. busy = (state != IDLE).
  - IDLE:
    - md_start & !stall: latch |a|,|b| for signed ops (raw for unsigned), latch opcode and result sign, clear the iteration counter -> RUN.
    - mt & !stall: write src_a to HI (mthi) or LO (mtlo) at this edge; stay IDLE.
  - RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle. After WIDTH steps -> FIX.
  - FIX: apply signs, write HI/LO at this edge -> IDLE.
- Latency: instruction accepted at edge N; HI/LO valid and busy low after edge N+WIDTH+1. Back-to-back md_start is accepted the first cycle busy is low.
- Arithmetic results:
  - mult/multu: {HI,LO} = full 2*WIDTH product. Signed product is negated when sign(a)^sign(b).
  - div/divu: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero; remainder takes the dividend's sign.
- Boundary conditions:
  - Divide by zero (any sign): LO = all ones, HI = src_a unmodified. Normal latency, no exception.
  - Signed div of most-negative value by -1: LO = most-negative value, HI = 0.
  - mf/mt/md_start while busy: stall held every cycle until busy falls. The instruction is then serviced with the final HI/LO.
  - instr_valid=0 never starts, writes, or stalls.
- Reset:
  - rst=1 at an edge: state IDLE; HI, LO, operand and counter registers cleared to 0.
  - busy=0 the following cycle.
  - Reset mid-operation aborts; HI/LO read 0.
- Internal registers are hidden; only hi/lo/busy are state-visible.

Test Plan:
- Decode sweep: alu_op 00/01/11 -> 0010/0110/0111. alu_op 10 with funct 100000, 100010, 100100, 100101, 101010, 100111 -> 0010, 0110, 0000, 0001, 0111, 1100. mfhi -> wb_sel 01, mflo -> wb_sel 10.
- mult src_a=0xFFFFFFFD (-3), src_b=5 -> after 33 edges HI=0xFFFFFFFF, LO=0xFFFFFFF1. busy high exactly 33 cycles. multu same operands -> HI=0x00000004, LO=0xFFFFFFF1.
- div 7 / 0xFFFFFFFE (-2) -> LO=0xFFFFFFFD, HI=0x00000001. divu 0xFFFFFFFF / 0x10 -> LO=0x0FFFFFFF, HI=0xF. div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- div 5 / 0 -> LO=0xFFFFFFFF, HI=0x00000005.
- mflo issued the cycle after mult accepts: stall=1 for 33 cycles, then 0, with lo showing the product. add during busy -> stall=0. mthi 0x1234 in IDLE -> hi=0x1234 next cycle.
- rst pulse at RUN step 10 of a mult -> next cycle busy=0, hi=lo=0. A new multu 3*4 then completes with LO=12, HI=0.
